// File: rtl/game_round_fsm.sv
// Game-flow controller: sequences NUM_ROUNDS rounds with a life budget, timed
// respawn, pause and a best-progress record that survives until Reset.
module game_round_fsm #(
  parameter int unsigned NUM_ROUNDS     = 4,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned RESPAWN_CYCLES = 16,
  localparam int unsigned RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
  localparam int unsigned LW = $clog2(LIVES + 1),
  localparam int unsigned TW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Ack,
  input  logic          Pause,
  input  logic          round_won,
  input  logic          collided,
  output logic [2:0]    state,
  output logic [RW-1:0] round,
  output logic [LW-1:0] lives,
  output logic [RW:0]   best_round,
  output logic          round_start
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_RESPAWN = 3'd2,
    S_PAUSED  = 3'd3,
    S_WIN     = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [RW:0]   best_q, best_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rs_q, rs_d;
  logic [RW:0]   cleared;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      lives_q <= '0;
      best_q  <= '0;
      timer_q <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      lives_q <= lives_d;
      best_q  <= best_d;
      timer_q <= timer_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    lives_d = lives_q;
    best_d  = best_q;
    timer_d = timer_q;
    rs_d    = 1'b0;
    // rounds cleared so far if the current round is won now
    cleared = (RW+1)'(round_q) + (RW+1)'(1);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_PLAY;
          round_d = '0;
          lives_d = LW'(LIVES);
          rs_d    = 1'b1;
        end
      end
      S_PLAY: begin
        if (collided) begin
          if (lives_q <= LW'(1)) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - LW'(1);
            timer_d = TW'(RESPAWN_CYCLES - 1);
            state_d = S_RESPAWN;
          end
        end else if (round_won) begin
          if (round_q == RW'(NUM_ROUNDS - 1)) begin
            state_d = S_WIN;
            best_d  = (RW+1)'(NUM_ROUNDS);
          end else begin
            round_d = round_q + RW'(1);
            rs_d    = 1'b1;
            if (cleared > best_q) best_d = cleared;
          end
        end else if (Pause) begin
          state_d = S_PAUSED;
        end
      end
      S_RESPAWN: begin
        if (timer_q == '0) begin
          state_d = S_PLAY;
          rs_d    = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_PAUSED: begin
        // resume is not a round start, so no strobe
        if (!Pause) state_d = S_PLAY;
      end
      S_WIN, S_OVER: begin
        if (Ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state       = state_q;
  assign round       = round_q;
  assign lives       = lives_q;
  assign best_round  = best_q;
  assign round_start = rs_q;

endmodule

// File: tb/tb_game_round_fsm.sv
// Scoreboard bench for game_round_fsm: directed scenarios plus random play,
// expected outputs from a rule-level model, compared by a separate monitor.
module tb_game_round_fsm;

  localparam int NR = 4;
  localparam int NL = 3;
  localparam int RC = 16;

  localparam int M_IDLE = 0, M_PLAY = 1, M_RESPAWN = 2, M_PAUSED = 3, M_WIN = 4, M_OVER = 5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0, Ack = 1'b0, Pause = 1'b0, round_won = 1'b0, collided = 1'b0;
  logic [2:0] state;
  logic [1:0] round;
  logic [1:0] lives;
  logic [2:0] best_round;
  logic       round_start;

  game_round_fsm #(.NUM_ROUNDS(NR), .LIVES(NL), .RESPAWN_CYCLES(RC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Pause(Pause),
    .round_won(round_won), .collided(collided), .state(state), .round(round),
    .lives(lives), .best_round(best_round), .round_start(round_start)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] rnd;
    logic [1:0] lv;
    logic [2:0] best;
    logic       rs;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rst_req = 1'b0;

  // reference model state, kept as plain game quantities
  int m_state = M_IDLE, m_round = 0, m_lives = 0, m_best = 0, m_left = 0;
  bit m_rs = 1'b0;

  function automatic void model_reset();
    m_state = M_IDLE; m_round = 0; m_lives = 0; m_best = 0; m_left = 0; m_rs = 1'b0;
  endfunction

  function automatic void model_step(bit s, bit a, bit p, bit w, bit c);
    m_rs = 1'b0;
    case (m_state)
      M_IDLE: if (s) begin m_state = M_PLAY; m_round = 0; m_lives = NL; m_rs = 1'b1; end
      M_PLAY: begin
        if (c) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_state = M_OVER;
          else begin m_state = M_RESPAWN; m_left = RC; end
        end else if (w) begin
          if (m_round + 1 == NR) begin m_state = M_WIN; m_best = NR; end
          else begin
            m_round = m_round + 1; m_rs = 1'b1;
            if (m_round > m_best) m_best = m_round;
          end
        end else if (p) m_state = M_PAUSED;
      end
      M_RESPAWN: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_state = M_PLAY; m_rs = 1'b1; end
      end
      M_PAUSED: if (!p) m_state = M_PLAY;
      default: if (a) m_state = M_IDLE;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = 3'(m_state); e.rnd = 2'(m_round); e.lv = 2'(m_lives);
    e.best = 3'(m_best); e.rs = m_rs;
    return e;
  endfunction

  // apply one cycle of inputs; the expected post-edge outputs go to the scoreboard
  task automatic drive(input bit s, input bit a, input bit p, input bit w, input bit c);
    @(negedge Clk);
    Reset = rst_req; Start = s; Ack = a; Pause = p; round_won = w; collided = c;
    if (rst_req) model_reset();
    else model_step(s, a, p, w, c);
    sb_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_now(input string tag);
    n_vec++;
    if ({state, round, lives, best_round, round_start} !== 11'd0) begin
      n_err++;
      $display("FAIL %s: got st=%0d rnd=%0d lv=%0d best=%0d rs=%0d, want all zero",
               tag, state, round, lives, best_round, round_start);
    end
  endtask

  task automatic async_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check_reset_now("async_reset");
    sb_q.delete();
    model_reset();
    rst_req = 1'b1;
    idle(2);
    rst_req = 1'b0;
  endtask

  task automatic lose_all();
    for (int i = 0; i < NL; i++) begin
      drive(0, 0, 0, 0, 1);
      idle(RC + 2);
    end
  endtask

  // monitor: every cycle the DUT presents a new output set
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (state !== e.st || round !== e.rnd || lives !== e.lv ||
            best_round !== e.best || round_start !== e.rs) begin
          n_err++;
          $display("FAIL cycle %0d outputs: got st=%0d rnd=%0d lv=%0d best=%0d rs=%0d, want st=%0d rnd=%0d lv=%0d best=%0d rs=%0d",
                   cyc, state, round, lives, best_round, round_start,
                   e.st, e.rnd, e.lv, e.best, e.rs);
        end
      end
    end
  end

  initial begin
    #1 check_reset_now("power_on_reset");
    rst_req = 1'b1;
    idle(2);
    rst_req = 1'b0;

    // inputs other than Start do nothing in IDLE
    drive(0, 1, 1, 1, 1);
    idle(2);

    // reset mid-respawn with best_round=2
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0); idle(2);
    drive(0, 0, 0, 1, 0); idle(2);
    drive(0, 0, 0, 0, 1); idle(3);
    async_reset();
    drive(0, 1, 1, 1, 1);
    idle(2);

    // best record across two games
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0); idle(2);
    drive(0, 0, 0, 1, 0); idle(2);
    lose_all();
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0); idle(2);
    lose_all();
    drive(0, 1, 0, 0, 0);

    // clean win
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) begin
      drive(0, 0, 0, 1, 0);
      idle(4);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    idle(2);

    // game over, round stays 0
    drive(1, 0, 0, 0, 0);
    lose_all();

    // Start held through OVER->IDLE begins a new game one cycle later
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // simultaneous collision and round_won on round 1
    drive(0, 0, 0, 1, 0); idle(2);
    drive(0, 0, 0, 1, 1);
    idle(RC + 2);

    // pause window with events inside it
    for (int i = 0; i < 10; i++) drive(0, 1, 1, (i == 3), (i == 6));
    idle(4);

    // random play
    for (int i = 0; i < 4000; i++) begin
      rst_req = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 6);
    end
    rst_req = 1'b0;
    idle(3);

    @(posedge Clk);
    #3;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
